// File: rtl/adder_pkg.sv
// Shared defaults, mode encoding and chunk sizing for the pipelined ripple-carry adder.
// No logic; imported by the adder top and its chunk cell.
package adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple of full-adder cells.
// Latency: 0 cycles (pure logic). Backpressure: none, no state.
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = w_c[W];
    assign c_msb_in = w_c[W-1];

endmodule

// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry add/subtract: one CHUNK of the carry chain resolved per stage.
// Latency: STAGES cycles accept-to-out_valid; 1 op/cycle sustained.
// Backpressure: ready_k = !valid_k || ready_{k+1}; empty stages fill while the output is stalled.
module pipelined_rc_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (WIDTH % STAGES != 0) begin : g_chk
        $error("pipelined_rc_adder: WIDTH must be a multiple of STAGES");
    end

    // Each stage keeps only the operand bits not yet consumed and the sum bits already finished,
    // so the operand registers shrink and the sum register grows by CHUNK per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRCW  = WIDTH - k * CHUNK;
        localparam int DONEW = (k + 1) * CHUNK;

        logic             w_src_vld;
        logic             w_src_c;
        logic [SRCW-1:0]  w_src_a;
        logic [SRCW-1:0]  w_src_b;
        logic [DONEW-1:0] w_s_nxt;
        logic [CHUNK-1:0] w_s;
        logic             w_co;
        logic             w_cm;
        logic             w_rdy;
        logic             w_rdy_nxt;
        logic             w_load;

        logic             r_vld;
        logic             r_c;
        logic [DONEW-1:0] r_s;

        if (k == 0) begin : g_in
            assign w_src_vld = in_valid;
            assign w_src_a   = a;
            assign w_src_b   = (sub == MODE_SUB) ? ~b : b;
            assign w_src_c   = (sub == MODE_SUB) ? 1'b1 : cin;
            assign w_s_nxt   = w_s;
        end else begin : g_in
            assign w_src_vld = g_stage[k-1].r_vld;
            assign w_src_a   = g_stage[k-1].g_fwd.r_a;
            assign w_src_b   = g_stage[k-1].g_fwd.r_b;
            assign w_src_c   = g_stage[k-1].r_c;
            assign w_s_nxt   = {w_s, g_stage[k-1].r_s};
        end

        rca_chunk #(.W(CHUNK)) u_chunk (
            .a        (w_src_a[CHUNK-1:0]),
            .b        (w_src_b[CHUNK-1:0]),
            .ci       (w_src_c),
            .s        (w_s),
            .co       (w_co),
            .c_msb_in (w_cm)
        );

        assign w_rdy  = !r_vld || w_rdy_nxt;
        assign w_load = w_rdy && w_src_vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_s   <= '0;
            end else begin
                if (w_rdy) begin
                    r_vld <= w_src_vld;
                end
                if (w_load) begin
                    r_c <= w_co;
                    r_s <= w_s_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [SRCW-CHUNK-1:0] r_a;
            logic [SRCW-CHUNK-1:0] r_b;
            logic                  w_cm_unused;

            assign w_rdy_nxt   = g_stage[k+1].w_rdy;
            assign w_cm_unused = w_cm;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_load) begin
                    r_a <= w_src_a[SRCW-1:CHUNK];
                    r_b <= w_src_b[SRCW-1:CHUNK];
                end
            end
        end else begin : g_last
            logic r_ov;

            assign w_rdy_nxt = out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ov <= 1'b0;
                end else if (w_load) begin
                    r_ov <= w_co ^ w_cm;
                end
            end
        end
    end

    assign in_ready  = g_stage[0].w_rdy;
    assign out_valid = g_stage[STAGES-1].r_vld;
    assign sum       = g_stage[STAGES-1].r_s;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = g_stage[STAGES-1].g_last.r_ov;

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Bench for pipelined_rc_adder: directed vector table, streaming/stall/reset sequences and
// randomized traffic against an arithmetic reference; also latency of STAGES=1 and STAGES=16 builds.
module tb_pipelined_rc_adder;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_valid1 = 1'b0, in_valid16 = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;
    logic         in_ready1, out_valid1, cout1, ovf1;
    logic [W-1:0] sum1;
    logic         in_ready16, out_valid16, cout16, ovf16;
    logic [W-1:0] sum16;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   n_wait = 0;
    bit   rnd_done = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    pipelined_rc_adder #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_rc_adder #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    pipelined_rc_adder #(.WIDTH(W), .STAGES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: unsigned sum from integer arithmetic, overflow from the signed range.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc, input logic ts);
        exp_t        e;
        int unsigned u;
        int          sv;
        if (ts) begin
            u  = 32'(ta) + 32'd65536 - 32'(tb);
            sv = int'($signed(ta)) - int'($signed(tb));
        end else begin
            u  = 32'(ta) + 32'(tb) + 32'(tc);
            sv = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
        end
        e.s = u[15:0];
        e.c = (u >= 32'd65536);
        e.v = (sv > 32767) || (sv < -32768);
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
        int n = 0;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            n_wait++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
        end else begin
            q.push_back(model(ta, tb, tc, ts));
            n_acc++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic lat_other(input bit big, input int exp_lat);
        int   lat = 0;
        logic ov;
        a = 16'h0008; b = 16'h0008; cin = 1'b0; sub = 1'b0;
        if (big) in_valid16 = 1'b1; else in_valid1 = 1'b1;
        @(negedge clk);
        chk(big ? "s16_in_ready" : "s1_in_ready", big ? in_ready16 : in_ready1, 1);
        @(posedge clk);
        #1 in_valid1 = 1'b0; in_valid16 = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            ov = big ? out_valid16 : out_valid1;
        end while (!ov && lat < 64);
        chk(big ? "s16_latency" : "s1_latency", lat, exp_lat);
        chk(big ? "s16_sum" : "s1_sum", big ? sum16 : sum1, 16'h0010);
        chk(big ? "s16_cout_ovf" : "s1_cout_ovf", big ? {cout16, ovf16} : {cout1, ovf1}, 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: any valid output must match the head of the expected queue, held or not.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: sum=%0h with nothing outstanding", sum);
            end else begin
                chk("sb_sum", sum, q[0].s);
                chk("sb_cout", cout, q[0].c);
                chk("sb_ovf", ovf, q[0].v);
                if (out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   lat;
        int   seen;
        int   acc0;
        int   out0;

        vecs[0] = '{16'h0008, 16'h0008, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0002, 16'h0008, 1'b0, 1'b1, 16'hFFFA, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0};
        vecs[6] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[9] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", {out_valid, out_valid1, out_valid16}, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout_ovf", {cout, ovf}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 50);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].s);
            chk($sformatf("vec%0d_cout", i), cout, vecs[i].c);
            chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].v);
            @(posedge clk);
            #1;
        end
        drain("vec_drain");

        // Eight back-to-back beats must stream out on eight consecutive cycles.
        n_wait = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                for (int i = 0; i < 8; i++) begin
                    chk($sformatf("b2b_valid%0d", i), out_valid, 1);
                    @(negedge clk);
                end
            end
        join
        chk("b2b_no_stall", n_wait, 0);
        drain("b2b_drain");

        // Stall the consumer: exactly four beats fit, then release.
        out_ready = 1'b0;
        acc0 = n_acc;
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (12) @(negedge clk);
                chk("full_in_ready", in_ready, 0);
                chk("full_out_valid", out_valid, 1);
                chk("full_occupancy", (n_acc - acc0) - (n_out - out0), 4);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stall_drain");
        chk("stall_total", n_out - out0, 6);

        // Random traffic with random consumer backpressure.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(pick(), pick(), 1'($urandom), 1'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain("rand_drain");

        // Reset with three beats in flight, the oldest already presented.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_sum", sum, 0);
        chk("rst_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_stale", seen, 0);
        @(posedge clk);
        #1;
        send(16'h0008, 16'h0008, 1'b0, 1'b0);
        drain("post_rst_drain");

        lat_other(1'b0, 1);
        lat_other(1'b1, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
